// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead byte FIFO behind the UART receiver, with a sticky overflow flag for dropped pushes.
// Ports: clk, rst (async active-high); in_valid/in_data push strobe from the receiver (no backpressure);
// out_valid/out_data/out_ready valid-ready drain; count = stored entries; full = count==DEPTH;
// overflow sticky drop flag, cleared by ovf_clr (a simultaneous drop wins).
// Optional: define UART_RX_FIFO_AFULL_EN to add registered almost_full (next count >= AFULL_THRESH).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
`ifdef UART_RX_FIFO_AFULL_EN
  output logic                  almost_full,
`endif
  input  logic                  ovf_clr
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_N = (DEPTH_LOG2 + 1)'(DEPTH);
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  valid_q, valid_d, full_q, full_d, overflow_q, overflow_d;
  logic                  pop, push_ok;
  always_comb begin
    pop        = valid_q && out_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    push_ok    = in_valid && (!full_q || pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d    = (push_ok && !pop) ? count_q + (DEPTH_LOG2 + 1)'(1) :
                 (pop && !push_ok) ? count_q - (DEPTH_LOG2 + 1)'(1) : count_q;
    valid_d    = count_d != '0;
    full_d     = count_d == DEPTH_N;
    // a drop in the same cycle as ovf_clr keeps the flag set
    overflow_d = (in_valid && !push_ok) || (overflow_q && !ovf_clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_data;
  end
  assign out_valid = valid_q;
  assign out_data  = valid_q ? mem_q[rd_ptr_q] : 8'h00;
  assign count     = count_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
`ifdef UART_RX_FIFO_AFULL_EN
  logic almost_full_q, almost_full_d;
  always_comb begin
    almost_full_d = 32'(count_d) >= AFULL_THRESH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= almost_full_d;
  end
  assign almost_full = almost_full_q;
`else
  logic unused_afull;
  assign unused_afull = |AFULL_THRESH;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (default parameters).
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_AFULL_EN
  logic       almost_full;
`endif
  int vectors = 0;
  int errs = 0;
  uart_rx_fifo #(.DEPTH_LOG2(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow),
`ifdef UART_RX_FIFO_AFULL_EN
    .almost_full(almost_full),
`endif
    .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] q[$];
    int sent;
    bit popped;
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 32'h00);
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("one_valid", 32'(out_valid), 1);
    chk("one_data", 32'(out_data), 32'hA5);
    chk("one_count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    chk("one_pop_valid", 32'(out_valid), 0);
    chk("one_pop_count", 32'(count), 0);
    chk("one_pop_data", 32'(out_data), 32'h00);
    step();
    chk("idle_ready_count", 32'(count), 0);
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    chk("empty_push_ready_count", 32'(count), 1);
    chk("empty_push_ready_data", 32'(out_data), 32'h77);
    step();
    out_ready = 1'b0;
    chk("empty_push_ready_drain", 32'(count), 0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf_before", 32'(overflow), 0);
    in_data = 8'hFF;
    step();
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(overflow), 1);
    in_data = 8'hEE; ovf_clr = 1'b1;
    step();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 1);
    chk("ovf_set_wins_count", 32'(count), 16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      step();
    end
    in_data = 8'h55; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_pushpop_count", 32'(count), 16);
    chk("full_pushpop_ovf", 32'(overflow), 0);
    chk("full_pushpop_full", 32'(full), 1);
    for (int i = 1; i < 16; i++) begin
      chk("full_pushpop_data", 32'(out_data), 32'(8'h10 + i));
      step();
    end
    chk("full_pushpop_last", 32'(out_data), 32'h55);
    step();
    out_ready = 1'b0;
    chk("full_pushpop_empty", 32'(count), 0);
    sent = 0;
    for (int c = 0; c < 300 && (sent < 40 || q.size() != 0); c++) begin
      in_valid = sent < 40;
      in_data = 8'(8'hC0 + sent * 7);
      out_ready = sent >= 40 ? 1'b1 : 1'($urandom_range(0, 1));
      chk("wrap_count", 32'(count), 32'(q.size()));
      if (q.size() != 0) chk("wrap_data", 32'(out_data), 32'(q[0]));
      popped = q.size() != 0 && out_ready;
      step();
      if (popped) void'(q.pop_front());
      if (in_valid) begin
        if (q.size() < 16) q.push_back(in_data);
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_drained", 32'(q.size()), 0);
    chk("wrap_all_sent", 32'(sent), 40);
    chk("wrap_final_count", 32'(count), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h90 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_data", 32'(out_data), 32'h00);
    step();
    rst = 1'b0;
    step();
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("post_rst_data", 32'(out_data), 32'h3C);
    chk("post_rst_count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_empty", 32'(count), 0);
`ifdef UART_RX_FIFO_AFULL_EN
    for (int i = 0; i < 12; i++) begin
      chk("afull_low", 32'(almost_full), 0);
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("afull_set", 32'(almost_full), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("afull_clear", 32'(almost_full), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte FIFO directly downstream of the UART receiver. It captures each single-cycle `data_valid`/`data` strobe from the receiver and buffers it. Downstream logic (7-seg driver, command handler, UART TX loopback) drains it through a valid/ready handshake. The receiver has no backpressure, so a push into a full FIFO drops the byte and sets a sticky overflow flag.

Parameters:
DEPTH_LOG2, 4, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 entries (default 16); legal range 1..8.
AFULL_THRESH, 12, almost-full threshold in entries; used only when UART_RX_FIFO_AFULL_EN is defined; legal range 1..DEPTH.

Ports:
clk  input  1  system clock (50 MHz in the board build)
rst  input  1  asynchronous reset, active-high
in_valid  input  1  push strobe; driven by the receiver's data_valid (1-cycle pulse)
in_data  input  8  byte to push; driven by the receiver's data
out_valid  output  1  FIFO non-empty; head byte present on out_data
out_data  output  8  head byte (show-ahead)
out_ready  input  1  consumer accepts head; pop occurs when out_valid && out_ready
count  output  DEPTH_LOG2+1  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: a push was dropped
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (async assert, sync release on clk):
  - wr_ptr, rd_ptr, count = 0
  - out_valid = 0, full = 0, overflow = 0, out_data = 8'h00
  - Storage array is not reset.
- Storage: DEPTH x 8 register array. wr_ptr/rd_ptr are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
- count, full and out_valid are registered. out_valid = (count != 0). out_data = mem[rd_ptr] while out_valid = 1, else 8'h00.
- push = in_valid. pop = out_valid && out_ready. All updates happen on the posedge.
- Push accepted when count < DEPTH, or when count == DEPTH and pop happens the same cycle. Accepted push: mem[wr_ptr] <= in_data, wr_ptr++.
- Push when full with no pop: byte dropped; wr_ptr and count unchanged; overflow <= 1.
- Pop: rd_ptr++.
- count update:
  - accepted push, no pop: +1
  - pop, no push: -1
  - both: unchanged (the full case remains full, no overflow)
- Latency: a byte pushed at edge N gives out_valid = 1 and correct out_data from just after edge N. Push-to-visible is 1 cycle.
- Push while empty with out_ready high: no pop that cycle (out_valid was 0). The byte appears next cycle.
- out_ready while out_valid = 0: ignored; pointers unchanged.
- overflow: stays set until ovf_clr. If ovf_clr and a drop occur in the same cycle, set wins (overflow = 1).
- in_valid held high for multiple cycles pushes one byte per cycle. No edge detection; the receiver guarantees a 1-cycle pulse.
- Reset mid-operation: contents discarded, FIFO empty immediately on rst assertion (outputs go to reset values asynchronously).

Optional Feature:
Macro UART_RX_FIFO_AFULL_EN.
- Defined:
  - Adds output port `almost_full` (1 bit), registered, reset 0.
  - almost_full = 1 when next-state count >= AFULL_THRESH, so it is cycle-aligned with count.
  - Intended to drive an RTS/flow-control pin.
- Undefined: port and logic absent; AFULL_THRESH unused.

Test Plan:
- Reset then idle 10 cycles -> out_valid=0, count=0, full=0, overflow=0, out_data=8'h00.
- Push 8'hA5 (1-cycle in_valid), out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, count=1. Then out_ready=1 for 1 cycle -> out_valid=0, count=0.
- Push 16 bytes 8'h00..8'h0F, then push 8'hFF -> full=1, count=16, overflow=1. Drain with out_ready=1 -> reads 8'h00..8'h0F in order; 8'hFF never appears. ovf_clr pulse -> overflow=0.
- Full FIFO, push 8'h55 with out_ready=1 the same cycle -> count stays 16, overflow stays 0. Final drained byte is 8'h55.
- Push/pop across wrap: 40 bytes with a random out_ready pattern -> output stream equals input stream; count never exceeds 16.
- Assert rst mid-stream with count=5 -> out_valid=0 and count=0 immediately. After release, a push of 8'h3C reads back as 8'h3C. With UART_RX_FIFO_AFULL_EN and AFULL_THRESH=12, the 12th push sets almost_full=1 and the following pop clears it.
